// File: rtl/bignum_chunk_serializer_pkg.sv
// Shared types and defaults for the big-number chunk serializer and its
// matching deserializer.
package bignum_chunk_serializer_pkg;

    localparam int DEF_BIT_SIZE    = 4096;
    localparam int DEF_CHUNK_SIZE  = 32;
    localparam int DEF_CHUNK_COUNT = DEF_BIT_SIZE / DEF_CHUNK_SIZE;

    typedef logic [DEF_CHUNK_SIZE-1:0] chunk_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/bignum_chunk_serializer_if.sv
// Operand-in / chunk-stream-out bundle for the serializer.
// The serializer takes the slave side.
interface bignum_chunk_serializer_if #(
    parameter int BIT_SIZE   = 4096,
    parameter int CHUNK_SIZE = 32
);
    localparam int CHUNK_COUNT = BIT_SIZE / CHUNK_SIZE;
    localparam int IDX_W       = $clog2(CHUNK_COUNT) + 1;

    logic                  valid_in;
    logic [BIT_SIZE-1:0]   data_in;
    logic                  ready_out;
    logic [CHUNK_SIZE-1:0] data_out;
    logic                  valid_out;
    logic                  first_out;
    logic                  last_out;
    logic [IDX_W-1:0]      chunk_idx_out;

    modport slave (
        input  valid_in,
        input  data_in,
        output ready_out,
        output data_out,
        output valid_out,
        output first_out,
        output last_out,
        output chunk_idx_out
    );

    modport master (
        output valid_in,
        output data_in,
        input  ready_out,
        input  data_out,
        input  valid_out,
        input  first_out,
        input  last_out,
        input  chunk_idx_out
    );

endinterface

// File: rtl/bignum_chunk_serializer.sv
// Serializes one wide operand into CHUNK_SIZE chunks, LSB chunk first,
// one per cycle with no backpressure; back-to-back words leave no gap.
module bignum_chunk_serializer
    import bignum_chunk_serializer_pkg::*;
#(
    parameter int BIT_SIZE   = DEF_BIT_SIZE,
    parameter int CHUNK_SIZE = DEF_CHUNK_SIZE
) (
    input logic                     clk_in,
    input logic                     rst_in,
    bignum_chunk_serializer_if.slave bus
);

    localparam int CHUNK_COUNT = BIT_SIZE / CHUNK_SIZE;
    localparam int IDX_W       = $clog2(CHUNK_COUNT) + 1;

    localparam logic [0:0]       S_IDLE   = 1'(IDLE);
    localparam logic [0:0]       S_SEND   = 1'(SEND);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNK_COUNT - 1);

    if ((CHUNK_SIZE > BIT_SIZE) || ((BIT_SIZE % CHUNK_SIZE) != 0)) begin : g_bad_size
        $fatal(1, "BIT_SIZE must be a whole multiple of CHUNK_SIZE");
    end

    logic [0:0]          state;
    logic [BIT_SIZE-1:0] shreg;
    logic [IDX_W-1:0]    idx;

    logic is_send;
    logic is_last;
    logic xfer;

    assign is_send = (state == S_SEND);
    assign is_last = is_send && (idx == LAST_IDX);

    // ready is gated by reset so nothing is accepted while rst_in is high
    assign bus.ready_out = !rst_in && (!is_send || is_last);
    assign xfer          = bus.valid_in && bus.ready_out;

    assign bus.data_out      = shreg[CHUNK_SIZE-1:0];
    assign bus.valid_out     = is_send;
    assign bus.first_out     = is_send && (idx == '0);
    assign bus.last_out      = is_last;
    assign bus.chunk_idx_out = idx;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
            shreg <= '0;
            idx   <= '0;
        end else if (xfer) begin
            state <= S_SEND;
            shreg <= bus.data_in;
            idx   <= '0;
        end else if (is_send && !is_last) begin
            shreg <= shreg >> CHUNK_SIZE;
            idx   <= idx + 1'b1;
        end else if (is_send) begin
            // drained without a follow-on word: clear so idle outputs read 0
            state <= S_IDLE;
            shreg <= '0;
            idx   <= '0;
        end
    end

endmodule

// File: tb/tb_bignum_chunk_serializer.sv
// Directed bench for bignum_chunk_serializer: 128/32 and 32/32 instances,
// plus a 3-stage delay line on the 128/32 stream.
module tb_bignum_chunk_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bignum_chunk_serializer_if #(.BIT_SIZE(128), .CHUNK_SIZE(32)) ia ();
    bignum_chunk_serializer_if #(.BIT_SIZE(32), .CHUNK_SIZE(32)) ib ();

    bignum_chunk_serializer #(.BIT_SIZE(128), .CHUNK_SIZE(32)) dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (ia)
    );

    bignum_chunk_serializer #(.BIT_SIZE(32), .CHUNK_SIZE(32)) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (ib)
    );

    logic [33:0] pipe [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe[0] <= '0;
            pipe[1] <= '0;
            pipe[2] <= '0;
        end else begin
            pipe[0] <= {ia.valid_out, ia.last_out, ia.data_out};
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end

    int xfers = 0;
    always @(negedge clk) begin
        if (ia.valid_in && ia.ready_out) xfers++;
    end

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] W   = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] WA  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] WB  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] WD  = 128'hDEADDEAD_DEADDEAD_DEADDEAD_DEADDEAD;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] oa();
        return {ia.valid_out, ia.first_out, ia.last_out, ia.ready_out,
                ia.chunk_idx_out, ia.data_out};
    endfunction

    function automatic logic [36:0] ob();
        return {ib.valid_out, ib.first_out, ib.last_out, ib.ready_out,
                ib.chunk_idx_out, ib.data_out};
    endfunction

    // expected 128/32 outputs in the k-th cycle after a transfer; k>=4 is idle
    function automatic logic [38:0] ea(input logic [127:0] w, input int k);
        logic [127:0] sh;
        if (k < 0 || k > 3) return {4'b0001, 3'd0, 32'd0};
        sh = w >> (32 * k);
        return {1'b1, 1'(k == 0), 1'(k == 3), 1'(k == 3), 3'(k), sh[31:0]};
    endfunction

    function automatic logic [33:0] ep(input logic [127:0] w, input int k);
        logic [127:0] sh;
        if (k < 0 || k > 3) return '0;
        sh = w >> (32 * k);
        return {1'b1, 1'(k == 3), sh[31:0]};
    endfunction

    function automatic logic [36:0] eb(input logic [31:0] v);
        return {4'b1111, 1'b0, v};
    endfunction

    int x0;

    initial begin
        ia.valid_in = 1'b0;
        ia.data_in  = '0;
        ib.valid_in = 1'b0;
        ib.data_in  = '0;
        #1;
        chk("rst_a", 64'(oa()), 64'(0));
        chk("rst_b", 64'(ob()), 64'(0));
        chk("rst_pipe", 64'(pipe[2]), 64'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        chk("release_a", 64'(oa()), 64'(ea(W, 4)));

        // basic word and its 3-cycle delayed copy
        ia.data_in  = W;
        ia.valid_in = 1'b1;
        step();
        ia.valid_in = 1'b0;
        ia.data_in  = '0;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("basic[%0d]", j), 64'(oa()), 64'(ea(W, j)));
            chk($sformatf("pipe[%0d]", j), 64'(pipe[2]), 64'(ep(W, j - 3)));
            step();
        end

        // back-to-back: B offered throughout A, accepted on A's last chunk
        ia.data_in  = WA;
        ia.valid_in = 1'b1;
        step();
        ia.data_in = WB;
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("b2b[%0d]", j), 64'(oa()),
                64'(ea(j < 4 ? WA : WB, j < 4 ? j : j - 4)));
            step();
            if (j == 3) ia.valid_in = 1'b0;
        end

        // offer while busy must be ignored
        x0 = xfers;
        ia.data_in  = WA;
        ia.valid_in = 1'b1;
        step();
        ia.valid_in = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("ignore[%0d]", j), 64'(oa()), 64'(ea(WA, j)));
            if (j == 1) begin
                ia.data_in  = WD;
                ia.valid_in = 1'b1;
            end
            step();
            ia.valid_in = 1'b0;
        end
        chk("xfer_count", 64'(xfers - x0), 64'(1));

        // reset in the middle of a word
        ia.data_in  = WA;
        ia.valid_in = 1'b1;
        step();
        ia.valid_in = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("mid[%0d]", j), 64'(oa()), 64'(ea(WA, j)));
            if (j < 2) step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst", 64'(oa()), 64'(0));
        chk("mid_rst_pipe", 64'(pipe[2]), 64'(0));
        step();
        rst = 1'b0;
        #1;
        chk("mid_release", 64'(oa()), 64'(ea(WA, 4)));
        ia.data_in  = W;
        ia.valid_in = 1'b1;
        step();
        ia.valid_in = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("reload[%0d]", j), 64'(oa()), 64'(ea(W, j)));
            step();
        end

        // single-chunk instance, one word per cycle
        ib.valid_in = 1'b1;
        ib.data_in  = 32'd1;
        step();
        chk("deg[0]", 64'(ob()), 64'(eb(32'd1)));
        ib.data_in = 32'd2;
        step();
        chk("deg[1]", 64'(ob()), 64'(eb(32'd2)));
        ib.data_in = 32'd3;
        step();
        ib.valid_in = 1'b0;
        chk("deg[2]", 64'(ob()), 64'(eb(32'd3)));
        step();
        chk("deg_idle", 64'(ob()), 64'({4'b0001, 1'b0, 32'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bignum_chunk_serializer.md
Name: bignum_chunk_serializer

Overview:
- Accepts one wide big-number operand (e.g. a 4096-bit Paillier ciphertext or modulus) through a ready/valid handshake.
- Emits the operand as a stream of fixed-width chunks, least-significant chunk first, one chunk per cycle, tagged with valid/first/last.
- Sits directly upstream of the chunk-domain arithmetic. Its chunk stream and flags feed pipeliner instances, which delay them to line up with multiplier/reducer latency.
- The stream has no backpressure: once started, a word always drains in exactly CHUNK_COUNT consecutive cycles.

Parameters:
- BIT_SIZE, 4096: width of the full operand. Must be an exact multiple of CHUNK_SIZE.
- CHUNK_SIZE, 32: width of each emitted chunk.
- CHUNK_COUNT, BIT_SIZE/CHUNK_SIZE: derived localparam, not overridable.

Ports:
- clk_in, input, 1: clock.
- rst_in, input, 1: reset. Asynchronous, active-high.
- valid_in, input, 1: producer offers data_in.
- data_in, input, BIT_SIZE: operand to serialize. Must be held stable while valid_in && !ready_out.
- ready_out, output, 1: block can accept a new operand this cycle.
- data_out, output, CHUNK_SIZE: current chunk.
- valid_out, output, 1: data_out holds a chunk.
- first_out, output, 1: current chunk is chunk 0 (LSB).
- last_out, output, 1: current chunk is chunk CHUNK_COUNT-1 (MSB).
- chunk_idx_out, output, $clog2(CHUNK_COUNT)+1: index of the current chunk.

Behaviour:
- Reset (async assert, sync use on deassert): state=IDLE; shift register, counter, data_out, valid_out, first_out, last_out and chunk_idx_out all 0. ready_out is forced 0 while rst_in is high.
- States:
  - IDLE: valid_out=0; ready_out=1.
  - SEND: valid_out=1; ready_out = last_out.
- Handshake: a transfer occurs at a posedge where valid_in && ready_out. A valid_in that is not accepted is ignored and nothing is captured; the producer must hold data_in.
- Latency: transfer at edge T -> chunk 0 is visible after edge T (cycle T+1). Chunk k is visible in cycle T+1+k. last_out is high in cycle T+CHUNK_COUNT.
- Chunk mapping: chunk k = data_in[k*CHUNK_SIZE +: CHUNK_SIZE], captured at transfer. Later changes to data_in do not affect an in-flight word.
- Implementation: registered shift register, shifted right by CHUNK_SIZE each SEND cycle. data_out = low CHUNK_SIZE bits of the register. chunk_idx_out is a counter.
- Transitions:
  - IDLE -> SEND on transfer.
  - SEND -> SEND while not last.
  - SEND on last chunk:
    - with a transfer in the same cycle (back-to-back): reload and stay in SEND. Chunk 0 of the new word follows the previous last chunk with no gap; first_out=1 in that next cycle.
    - without a transfer: -> IDLE, with all outputs zeroed except ready_out.
- first_out and last_out are valid only with valid_out; both are 0 when valid_out=0.
- CHUNK_COUNT==1: first_out and last_out are high together on every valid cycle. ready_out stays high in SEND, so one word per cycle is accepted when valid_in is held.
- Reset mid-stream: the word is abandoned and valid_out drops immediately (async). After release the block starts in IDLE with ready_out=1 from the first clock. No partial word is resumed.
- No arithmetic or carry handling. Chunk widths are exact and no padding is needed, given the divisibility rule.
- Elaboration check: BIT_SIZE % CHUNK_SIZE != 0 or CHUNK_SIZE > BIT_SIZE is a fatal error.

Decomposition:
- Shared package:
  - default BIT_SIZE and CHUNK_SIZE constants.
  - a chunk_t typedef (logic [CHUNK_SIZE-1:0]).
  - a CHUNK_COUNT constant.
  - the state enum {IDLE, SEND}, because the matching deserializer reuses it.
- No sub-module: the counter and shift register stay inline.
- Downstream alignment uses existing pipeliner instances, one per signal group. It is not part of this block.

Test Plan:
- Bench parameters: BIT_SIZE=128, CHUNK_SIZE=32.
- Basic word: load 0x44444444_33333333_22222222_11111111 at edge T -> data_out = 11111111, 22222222, 33333333, 44444444 in cycles T+1..T+4. first_out only at T+1, last_out only at T+4. ready_out low T+1..T+3, high at T+4. Returns to IDLE at T+5.
- Back-to-back: hold valid_in with word A=0x...A3A2A1A0 then B=0x...B3B2B1B0, B offered during A's last cycle -> eight consecutive valid chunks A0..A3, B0..B3 with no gap. first_out at chunks 1 and 5; last_out at chunks 4 and 8.
- Ignored offer: pulse valid_in with 0xDEAD... during A's chunk 1 -> not captured. Stream remains A0..A3. Exactly one transfer is counted.
- Reset mid-stream: assert rst_in during chunk 2 -> valid_out=0 and ready_out=0 immediately. After release ready_out=1. A new load streams from chunk 0 correctly.
- Degenerate: CHUNK_SIZE=BIT_SIZE=32 with valid_in held and data incrementing 1, 2, 3 -> data_out 1, 2, 3 on consecutive cycles, first_out=last_out=1 each cycle.
- Alignment: pass {valid_out, last_out, data_out} through a 3-stage pipeliner -> identical sequence delayed exactly 3 cycles, all zeros while in reset.
